// File: rtl/memory_access_sequencer.sv
// rtl/memory_access_sequencer.sv - load/store mode sequencer in front of the memory controller
// Optional word-store fast path: define MEMORY_SEQUENCER_WORD_STORE_FASTPATH_EN.
module memory_access_sequencer #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqIsStore,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqRs1,
  input  logic [31:0] reqRs2,
  input  logic [31:0] reqImmediateI,
  input  logic [31:0] reqImmediateS,
  output logic [1:0]  memoryMode,
  output logic [2:0]  funct3,
  output logic [31:0] rs1,
  output logic [31:0] rs2,
  output logic [31:0] immediateI,
  output logic [31:0] immediateS,
  input  logic [31:0] memoryOutput,
  input  logic        memoryUnalignedAccess,
  input  logic        memoryBadFunct3,
  output logic        rdWriteEnable,
  output logic [31:0] rdValue,
  output logic        accessDone,
  output logic        errorHalt,
  output logic [1:0]  errorCause
);

  localparam logic [1:0] MODE_NOP           = 2'd0;
  localparam logic [1:0] MODE_LOAD          = 2'd1;
  localparam logic [1:0] MODE_STORE_PRELOAD = 2'd2;
  localparam logic [1:0] MODE_STORE         = 2'd3;

  localparam logic [2:0] LOAD_LAST = 3'(READ_LATENCY);
  localparam logic [2:0] PRE_LAST  = 3'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_STORE_PRE,
    S_STORE_WRITE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [1:0]  mode_q, mode_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] imm_i_q, imm_i_d;
  logic [31:0] imm_s_q, imm_s_d;
  logic [31:0] rd_value_q, rd_value_d;
  logic        rd_we_q, rd_we_d;
  logic        done_q, done_d;
  logic        halt_q, halt_d;
  logic [1:0]  cause_q, cause_d;
  logic        ready_q, ready_d;
  logic        fault;
  logic        fast_store;

`ifdef MEMORY_SEQUENCER_WORD_STORE_FASTPATH_EN
  // Only the low two address bits matter for word alignment.
  logic [1:0] store_addr_lo;
  assign store_addr_lo = reqRs1[1:0] + reqImmediateS[1:0];
  assign fast_store    = (reqFunct3 == 3'b010) && (store_addr_lo == 2'b00);
`else
  assign fast_store = 1'b0;
`endif

  assign fault = memoryUnalignedAccess || memoryBadFunct3;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    funct3_d   = funct3_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    imm_i_d    = imm_i_q;
    imm_s_d    = imm_s_q;
    rd_value_d = rd_value_q;
    rd_we_d    = 1'b0;
    done_d     = 1'b0;
    halt_d     = halt_q;
    cause_d    = cause_q;

    case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          funct3_d = reqFunct3;
          rs1_d    = reqRs1;
          rs2_d    = reqRs2;
          imm_i_d  = reqImmediateI;
          imm_s_d  = reqImmediateS;
          wait_d   = 3'd0;
          if (!reqIsStore) state_d = S_LOAD_WAIT;
          else if (fast_store) state_d = S_STORE_WRITE;
          else state_d = S_STORE_PRE;
        end
      end
      S_LOAD_WAIT: begin
        if (fault) begin
          state_d = S_ERROR;
        end else if (wait_q == LOAD_LAST) begin
          rd_value_d = memoryOutput;
          rd_we_d    = 1'b1;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_STORE_PRE: begin
        if (fault) state_d = S_ERROR;
        else if (wait_q == PRE_LAST) state_d = S_STORE_WRITE;
        else wait_d = wait_q + 3'd1;
      end
      S_STORE_WRITE: begin
        if (fault) begin
          state_d = S_ERROR;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_ERROR;
    endcase

    // Cause bits are only merged on the transition into ERROR; flags are ignored afterwards.
    if (state_q != S_ERROR && state_q != S_IDLE && fault) begin
      halt_d  = 1'b1;
      cause_d = cause_q | {memoryBadFunct3, memoryUnalignedAccess};
    end

    case (state_d)
      S_LOAD_WAIT:   mode_d = MODE_LOAD;
      S_STORE_PRE:   mode_d = MODE_STORE_PRELOAD;
      S_STORE_WRITE: mode_d = MODE_STORE;
      default:       mode_d = MODE_NOP;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_q     <= 3'd0;
      mode_q     <= MODE_NOP;
      funct3_q   <= 3'd0;
      rs1_q      <= 32'd0;
      rs2_q      <= 32'd0;
      imm_i_q    <= 32'd0;
      imm_s_q    <= 32'd0;
      rd_value_q <= 32'd0;
      rd_we_q    <= 1'b0;
      done_q     <= 1'b0;
      halt_q     <= 1'b0;
      cause_q    <= 2'd0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      mode_q     <= mode_d;
      funct3_q   <= funct3_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_i_q    <= imm_i_d;
      imm_s_q    <= imm_s_d;
      rd_value_q <= rd_value_d;
      rd_we_q    <= rd_we_d;
      done_q     <= done_d;
      halt_q     <= halt_d;
      cause_q    <= cause_d;
      ready_q    <= ready_d;
    end
  end

  assign reqReady      = ready_q;
  assign memoryMode    = mode_q;
  assign funct3        = funct3_q;
  assign rs1           = rs1_q;
  assign rs2           = rs2_q;
  assign immediateI    = imm_i_q;
  assign immediateS    = imm_s_q;
  assign rdWriteEnable = rd_we_q;
  assign rdValue       = rd_value_q;
  assign accessDone    = done_q;
  assign errorHalt     = halt_q;
  assign errorCause    = cause_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// tb/tb_memory_access_sequencer.sv - directed table-driven bench for memory_access_sequencer
// Two instances (READ_LATENCY 1 and 3) share one stimulus stream.
module tb_memory_access_sequencer;

  localparam logic [1:0] NOP = 2'd0;
  localparam logic [1:0] LD  = 2'd1;
  localparam logic [1:0] PRE = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqIsStore = 1'b0;
  logic [2:0]  reqFunct3 = 3'd0;
  logic [31:0] reqRs1 = 32'd0, reqRs2 = 32'd0, reqImmediateI = 32'd0, reqImmediateS = 32'd0;
  logic [31:0] memoryOutput = 32'd0;
  logic        memoryUnalignedAccess = 1'b0;
  logic        memoryBadFunct3 = 1'b0;

  logic        ready_1, ready_3, rd_we_1, rd_we_3, done_1, done_3, halt_1, halt_3;
  logic [1:0]  mode_1, mode_3, cause_1, cause_3;
  logic [2:0]  f3_1, f3_3;
  logic [31:0] rs1_1, rs1_3, rs2_1, rs2_3, immi_1, immi_3, imms_1, imms_3, rdv_1, rdv_3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  memory_access_sequencer #(.READ_LATENCY(1)) dut_1 (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(ready_1),
    .reqIsStore(reqIsStore), .reqFunct3(reqFunct3), .reqRs1(reqRs1), .reqRs2(reqRs2),
    .reqImmediateI(reqImmediateI), .reqImmediateS(reqImmediateS), .memoryMode(mode_1),
    .funct3(f3_1), .rs1(rs1_1), .rs2(rs2_1), .immediateI(immi_1), .immediateS(imms_1),
    .memoryOutput(memoryOutput), .memoryUnalignedAccess(memoryUnalignedAccess),
    .memoryBadFunct3(memoryBadFunct3), .rdWriteEnable(rd_we_1), .rdValue(rdv_1),
    .accessDone(done_1), .errorHalt(halt_1), .errorCause(cause_1)
  );

  memory_access_sequencer #(.READ_LATENCY(3)) dut_3 (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqReady(ready_3),
    .reqIsStore(reqIsStore), .reqFunct3(reqFunct3), .reqRs1(reqRs1), .reqRs2(reqRs2),
    .reqImmediateI(reqImmediateI), .reqImmediateS(reqImmediateS), .memoryMode(mode_3),
    .funct3(f3_3), .rs1(rs1_3), .rs2(rs2_3), .immediateI(immi_3), .immediateS(imms_3),
    .memoryOutput(memoryOutput), .memoryUnalignedAccess(memoryUnalignedAccess),
    .memoryBadFunct3(memoryBadFunct3), .rdWriteEnable(rd_we_3), .rdValue(rdv_3),
    .accessDone(done_3), .errorHalt(halt_3), .errorCause(cause_3)
  );

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, imm_i, imm_s, mem_out;
    logic [15:0] m1, m3;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Mode trace for cycles 1..5 after acceptance; bits [1:0] hold cycle 1.
  function automatic logic [15:0] tr(input logic [1:0] a, b, c, d, e);
    return {NOP, NOP, NOP, e, d, c, b, a};
  endfunction

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] r1, r2,
                              input logic [31:0] ii, is, mo, input logic [15:0] m1, m3);
    vec_t v;
    v.is_store = st; v.f3 = f3; v.rs1 = r1; v.rs2 = r2;
    v.imm_i = ii; v.imm_s = is; v.mem_out = mo; v.m1 = m1; v.m3 = m3;
    return v;
  endfunction

  task automatic drive_req(input vec_t v);
    @(negedge clock);
    check("ready_before_req_rl1", 64'(ready_1), 64'd1);
    check("ready_before_req_rl3", 64'(ready_3), 64'd1);
    reqValid = 1'b1; reqIsStore = v.is_store; reqFunct3 = v.f3;
    reqRs1 = v.rs1; reqRs2 = v.rs2; reqImmediateI = v.imm_i; reqImmediateS = v.imm_s;
    memoryOutput = v.mem_out;
  endtask

  task automatic apply_vec(input int idx);
    logic [15:0] t1, t3;
    int we1, we3, dn1, dn3;
    vec_t v;
    v = vecs[idx];
    t1 = '0; t3 = '0; we1 = 0; we3 = 0; dn1 = 0; dn3 = 0;
    drive_req(v);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) begin
        reqValid = 1'b0;
        check($sformatf("v%0d_rs1_imm", idx), {rs1_1, v.is_store ? imms_1 : immi_1},
              {v.rs1, v.is_store ? v.imm_s : v.imm_i});
        check($sformatf("v%0d_rs2_f3", idx), {29'd0, f3_1, rs2_1}, {29'd0, v.f3, v.rs2});
        check($sformatf("v%0d_ready_busy", idx), 64'(ready_1), 64'd0);
      end
      if (k <= 8) begin
        t1[2*(k-1) +: 2] = mode_1;
        t3[2*(k-1) +: 2] = mode_3;
      end
      we1 += int'(rd_we_1); we3 += int'(rd_we_3);
      dn1 += int'(done_1);  dn3 += int'(done_3);
      if (rd_we_1) check($sformatf("v%0d_rdv_at_strobe_rl1", idx), 64'(rdv_1), 64'(v.mem_out));
    end
    check($sformatf("v%0d_modes_rl1", idx), 64'(t1), 64'(v.m1));
    check($sformatf("v%0d_modes_rl3", idx), 64'(t3), 64'(v.m3));
    check($sformatf("v%0d_rdwe_rl1", idx), 64'(we1), v.is_store ? 64'd0 : 64'd1);
    check($sformatf("v%0d_rdwe_rl3", idx), 64'(we3), v.is_store ? 64'd0 : 64'd1);
    check($sformatf("v%0d_done_rl1", idx), 64'(dn1), 64'd1);
    check($sformatf("v%0d_done_rl3", idx), 64'(dn3), 64'd1);
    if (!v.is_store) check($sformatf("v%0d_rdv_rl3", idx), 64'(rdv_3), 64'(v.mem_out));
  endtask

  initial begin
    vecs[0] = mk(1'b0, 3'b010, 32'h100, 32'h0, 32'h4, 32'h0, 32'hDEADBEEF,
                 tr(LD, LD, NOP, NOP, NOP), tr(LD, LD, LD, LD, NOP));
    vecs[1] = mk(1'b1, 3'b000, 32'h200, 32'hAB, 32'h0, 32'h3, 32'h0,
                 tr(PRE, ST, NOP, NOP, NOP), tr(PRE, PRE, PRE, ST, NOP));
`ifdef MEMORY_SEQUENCER_WORD_STORE_FASTPATH_EN
    vecs[2] = mk(1'b1, 3'b010, 32'h300, 32'h11223344, 32'h0, 32'h0, 32'h0,
                 tr(ST, NOP, NOP, NOP, NOP), tr(ST, NOP, NOP, NOP, NOP));
`else
    vecs[2] = mk(1'b1, 3'b010, 32'h300, 32'h11223344, 32'h0, 32'h0, 32'h0,
                 tr(PRE, ST, NOP, NOP, NOP), tr(PRE, PRE, PRE, ST, NOP));
`endif
    vecs[3] = mk(1'b1, 3'b010, 32'h302, 32'h55667788, 32'h0, 32'h0, 32'h0,
                 tr(PRE, ST, NOP, NOP, NOP), tr(PRE, PRE, PRE, ST, NOP));
    vecs[4] = mk(1'b0, 3'b100, 32'h800, 32'h0, 32'hFFFFFFFC, 32'h0, 32'h12345678,
                 tr(LD, LD, NOP, NOP, NOP), tr(LD, LD, LD, LD, NOP));
    vecs[5] = mk(1'b1, 3'b001, 32'h400, 32'hBEEF, 32'h0, 32'h2, 32'h0,
                 tr(PRE, ST, NOP, NOP, NOP), tr(PRE, PRE, PRE, ST, NOP));

    repeat (3) @(negedge clock);
    check("reset_mode", {62'd0, mode_1}, 64'(NOP));
    check("reset_operands", {rs1_1 | rs2_1 | immi_1 | imms_1, 29'd0, f3_1}, 64'd0);
    check("reset_rdvalue", 64'(rdv_1), 64'd0);
    check("reset_flags", {58'd0, rd_we_1, done_1, halt_1, cause_1, ready_1}, 64'd1);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) apply_vec(i);

    // Read data must be sampled only in the final LOAD cycle.
    drive_req(vecs[0]);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) reqValid = 1'b0;
      memoryOutput = 32'hA0000000 + 32'(k);
    end
    check("late_sample_rl1", 64'(rdv_1), 64'hA0000002);
    check("late_sample_rl3", 64'(rdv_3), 64'hA0000004);

    // Reset during the second LOAD cycle abandons the access.
    drive_req(vecs[4]);
    @(negedge clock);
    reqValid = 1'b0;
    @(negedge clock);
    check("mid_reset_still_load", {62'd0, mode_1}, 64'(LD));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_reset_mode", {60'd0, mode_1, mode_3}, 64'd0);
    check("mid_reset_strobes", {60'd0, rd_we_1, rd_we_3, done_1, done_3}, 64'd0);
    check("mid_reset_ready", {62'd0, ready_1, ready_3}, 64'd3);
    check("mid_reset_cause_rdv", {30'd0, cause_1, rdv_1}, 64'd0);
    apply_vec(0);

    // Unaligned fault during STORE_PRELOAD: STORE never driven, core halts.
    drive_req(mk(1'b1, 3'b001, 32'h400, 32'h1234, 32'h0, 32'h1, 32'h0, 16'h0, 16'h0));
    @(negedge clock);
    reqValid = 1'b0;
    check("fault_pre_mode", {62'd0, mode_1}, 64'(PRE));
    memoryUnalignedAccess = 1'b1;
    @(negedge clock);
    memoryUnalignedAccess = 1'b0;
    check("fault_mode_nop", {60'd0, mode_1, mode_3}, 64'd0);
    check("fault_halt", {62'd0, halt_1, halt_3}, 64'd3);
    check("fault_cause_rl1", 64'(cause_1), 64'd1);
    check("fault_cause_rl3", 64'(cause_3), 64'd1);
    check("fault_no_done", {62'd0, done_1, done_3}, 64'd0);
    reqValid = 1'b1;
    reqIsStore = 1'b0;
    memoryBadFunct3 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (k == 3) memoryBadFunct3 = 1'b0;
      check($sformatf("halted_c%0d", k), {56'd0, ready_1, ready_3, mode_1, mode_3, done_1, rd_we_1},
            64'd0);
    end
    reqValid = 1'b0;
    check("halted_cause_sticky", {60'd0, cause_1, cause_3}, 64'h5);
    check("halted_flag", {62'd0, halt_1, halt_3}, 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_sequencer.md
Name: memory_access_sequencer

Overview:
- Multi-cycle sequencer directly upstream of the memory controller.
- Accepts one load/store request from the control unit and latches the operands.
- Drives memoryMode through the legal sequence: LOAD, STORE_PRELOAD then STORE, or STORE alone.
- Captures the load result for rd writeback, monitors the controller's error flags, and halts the core on a fault.

Parameters:
- READ_LATENCY, 1, posedges between the first cycle a read address is presented and read data being valid at memoryOutput/backend (1 = synchronous block RAM). Legal range 1..4.

Ports:
- Interface fixed: single clock `clock`; `reset` is synchronous, active-high.
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- reqValid  in  1  request present
- reqReady  out  1  sequencer can accept a request
- reqIsStore  in  1  1 = store, 0 = load
- reqFunct3  in  3  RISC-V funct3 of the access
- reqRs1  in  32  base register value
- reqRs2  in  32  store data
- reqImmediateI  in  32  load offset
- reqImmediateS  in  32  store offset
- memoryMode  out  MemoryMode_t  mode to the controller (NOP/LOAD/STORE_PRELOAD/STORE)
- funct3, rs1, rs2, immediateI, immediateS  out  3/32/32/32/32  latched operands to the controller
- memoryOutput  in  32  load data from the controller
- memoryUnalignedAccess  in  1  controller error flag
- memoryBadFunct3  in  1  controller error flag
- rdWriteEnable  out  1  one-cycle strobe: rdValue valid
- rdValue  out  32  captured load result
- accessDone  out  1  one-cycle strobe: access retired (load or store)
- errorHalt  out  1  sticky fault
- errorCause  out  2  bit0 = unaligned, bit1 = bad funct3 (sticky)

Behaviour:
- Reset values:
  - memoryMode = NOP; operand outputs = 0; rdValue = 0.
  - rdWriteEnable, accessDone, errorHalt = 0; errorCause = 0.
  - reqReady = 1; state = IDLE.
- Handshake:
  - Accept when reqValid && reqReady at a posedge; operands are latched at that edge.
  - reqReady = 1 only in IDLE. No back-to-back acceptance: at least one IDLE cycle between accesses.
- States: IDLE, LOAD_WAIT, STORE_PRE, STORE_WRITE, ERROR.
- IDLE:
  - memoryMode = NOP.
  - On accept with load → LOAD_WAIT, waitCount = 0.
  - On accept with store → STORE_PRE, or STORE_WRITE when the fast path applies (see Optional Feature).
- LOAD_WAIT:
  - memoryMode = LOAD held stable for READ_LATENCY+1 cycles; waitCount increments each cycle.
  - In the final cycle (waitCount == READ_LATENCY): rdValue ← memoryOutput, rdWriteEnable = 1 and accessDone = 1 next cycle, → IDLE.
- STORE_PRE:
  - memoryMode = STORE_PRELOAD for READ_LATENCY cycles, then → STORE_WRITE.
- STORE_WRITE:
  - memoryMode = STORE for exactly 1 cycle (the controller writes that edge).
  - accessDone = 1 next cycle, → IDLE.
- Error check, sampled every cycle in LOAD_WAIT, STORE_PRE and STORE_WRITE:
  - If memoryUnalignedAccess || memoryBadFunct3: → ERROR.
  - errorCause |= {badFunct3, unaligned}; errorHalt = 1.
  - No rdWriteEnable and no accessDone for the faulting access.
  - A fault detected in STORE_PRE prevents STORE from ever being driven.
- ERROR:
  - memoryMode = NOP, reqReady = 0.
  - Stays until reset; flags are ignored.
- Strobes: rdWriteEnable and accessDone are registered single-cycle pulses, asserted in the cycle after the last LOAD/STORE cycle (that cycle is IDLE).
- Reset mid-access: the next cycle is IDLE/NOP. A STORE cycle interrupted by reset is still written by the controller (reset is sampled at the same edge); no partial state is retained.
- reqValid while busy is ignored. Request inputs are don't-care when not accepted.
- Latency at READ_LATENCY = 1:
  - Load: 2 cycles LOAD.
  - sb/sh: 1 cycle STORE_PRELOAD + 1 cycle STORE.
  - sw: 2 cycles (1 with the fast path).

Optional Feature:
- Macro: MEMORY_SEQUENCER_WORD_STORE_FASTPATH_EN.
- Defined:
  - On accept, if reqIsStore && reqFunct3 == 3'b010 && (reqRs1 + reqImmediateS)[1:0] == 2'b00 (computed locally), go straight to STORE_WRITE and skip STORE_PRELOAD.
  - Every other store uses STORE_PRE.
- Undefined:
  - All stores pass through STORE_PRE.
  - No local adder is synthesized.

Test Plan:
- Load, READ_LATENCY=1: rs1=0x100, immI=4, funct3=010, memoryOutput=0xDEADBEEF.
  - memoryMode = LOAD for exactly 2 cycles.
  - Then rdWriteEnable=1, rdValue=0xDEADBEEF, accessDone=1 for one cycle; reqReady back to 1.
- sb: rs1=0x200, immS=3, rs2=0xAB.
  - Modes NOP→STORE_PRELOAD(1)→STORE(1)→NOP.
  - accessDone pulses once; rdWriteEnable stays 0.
- sw at 0x300:
  - With the macro: STORE for 1 cycle, no STORE_PRELOAD.
  - Without: STORE_PRELOAD then STORE.
  - Misaligned sw at 0x302 with the macro: takes the PRELOAD path.
- Fault: sh with memoryUnalignedAccess=1 during STORE_PRELOAD.
  - STORE is never driven; errorHalt=1, errorCause=2'b01.
  - reqReady stays 0 for 20 further cycles despite reqValid=1.
- READ_LATENCY=3 load: memoryMode = LOAD for 4 cycles; value sampled only in the 4th.
- Reset asserted in the 2nd LOAD cycle:
  - Next cycle memoryMode=NOP, no rdWriteEnable, reqReady=1, errorCause=0.
  - A new load then completes normally.
